// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and operand bundle for serial_magnitude_comparator.
// The requester drives start/operands; the comparator drives status and result.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             lesser;
    logic             greater;
    logic             equal;
    logic [CW-1:0]    cycles;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, lesser, greater, equal, cycles
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, lesser, greater, equal, cycles
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator scanning DIGIT bits per clock, MSB first.
// Signed operands are mapped to offset binary at capture so the scan itself is always unsigned.
module serial_magnitude_comparator #(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    serial_magnitude_comparator_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_magnitude_comparator: WIDTH must be >= 2");
    end
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;
    logic             r_dec_lt;
    logic             r_dec_gt;
    logic             r_busy;
    logic             r_done;
    logic             r_lesser;
    logic             r_greater;
    logic             r_equal;
    logic [CW-1:0]    r_cycles;

    logic [31:0]      w_base;
    logic [DIGIT-1:0] w_sa;
    logic [DIGIT-1:0] w_sb;
    logic             w_undecided;
    logic             w_new_lt;
    logic             w_new_gt;
    logic             w_lt;
    logic             w_gt;
    logic             w_finish;
    logic [CW-1:0]    w_cnt_nxt;

    assign w_base      = 32'(r_idx) * 32'(DIGIT);
    assign w_sa        = r_a[w_base +: DIGIT];
    assign w_sb        = r_b[w_base +: DIGIT];
    assign w_undecided = !(r_dec_lt || r_dec_gt);
    assign w_new_lt    = w_undecided && (w_sa < w_sb);
    assign w_new_gt    = w_undecided && (w_sa > w_sb);
    assign w_lt        = r_dec_lt || w_new_lt;
    assign w_gt        = r_dec_gt || w_new_gt;
    assign w_cnt_nxt   = r_cnt + CW'(1);
    // Without early exit the first decision is frozen and the remaining digits are still walked.
    assign w_finish    = ((EARLY_EXIT != 0) && (w_new_lt || w_new_gt)) || (r_idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_dec_lt  <= 1'b0;
            r_dec_gt  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_lesser  <= 1'b0;
            r_greater <= 1'b0;
            r_equal   <= 1'b0;
            r_cycles  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.signed_mode ? (bus.a ^ MSB_MASK) : bus.a;
                        r_b      <= bus.signed_mode ? (bus.b ^ MSB_MASK) : bus.b;
                        r_idx    <= IW'(N - 1);
                        r_cnt    <= '0;
                        r_dec_lt <= 1'b0;
                        r_dec_gt <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_finish) begin
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_lesser  <= w_lt;
                        r_greater <= w_gt;
                        r_equal   <= !(w_lt || w_gt);
                        r_cycles  <= w_cnt_nxt;
                        r_state   <= IDLE;
                    end else begin
                        r_idx    <= r_idx - IW'(1);
                        r_cnt    <= w_cnt_nxt;
                        r_dec_lt <= w_lt;
                        r_dec_gt <= w_gt;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.lesser  = r_lesser;
    assign bus.greater = r_greater;
    assign bus.equal   = r_equal;
    assign bus.cycles  = r_cycles;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: three configurations driven in parallel
// (D2 early-exit, D2 full-scan, D8 single-cycle), checked against an arithmetic model.
module tb_serial_magnitude_comparator;
    logic clk;
    logic rst_n;
    logic       t_start;
    logic [7:0] t_a;
    logic [7:0] t_b;
    logic       t_sm;

    int total = 0;
    int bad   = 0;

    localparam int DG [3] = '{2, 2, 8};
    localparam int EE [3] = '{1, 0, 1};

    serial_magnitude_comparator_if #(.WIDTH(8), .DIGIT(2)) if0 ();
    serial_magnitude_comparator_if #(.WIDTH(8), .DIGIT(2)) if1 ();
    serial_magnitude_comparator_if #(.WIDTH(8), .DIGIT(8)) if2 ();

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(8), .EARLY_EXIT(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.start = t_start; assign if0.a = t_a; assign if0.b = t_b; assign if0.signed_mode = t_sm;
    assign if1.start = t_start; assign if1.a = t_a; assign if1.b = t_b; assign if1.signed_mode = t_sm;
    assign if2.start = t_start; assign if2.a = t_a; assign if2.b = t_b; assign if2.signed_mode = t_sm;

    logic [2:0]      w_busy, w_done, w_lt, w_gt, w_eq;
    logic [2:0][3:0] w_cyc;
    assign w_busy = {if2.busy, if1.busy, if0.busy};
    assign w_done = {if2.done, if1.done, if0.done};
    assign w_lt   = {if2.lesser, if1.lesser, if0.lesser};
    assign w_gt   = {if2.greater, if1.greater, if0.greater};
    assign w_eq   = {if2.equal, if1.equal, if0.equal};
    assign w_cyc[0] = 4'(if0.cycles);
    assign w_cyc[1] = 4'(if1.cycles);
    assign w_cyc[2] = 4'(if2.cycles);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Results of instance 0 from the most recent do_cmp.
    int r0_lt, r0_gt, r0_eq, r0_cyc;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        int         lt;
        int         gt;
        int         eq;
        int         cyc;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // rel: -1 a<b, 0 equal, 1 a>b. k: scan cycles (position of the highest differing bit).
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic sm,
                                  input int dg, input int ee, output int rel, output int k);
        int n;
        int p;
        logic [7:0] x;
        n = 8 / dg;
        x = a ^ b;
        if (sm) rel = ($signed(a) < $signed(b)) ? -1 : (($signed(a) > $signed(b)) ? 1 : 0);
        else    rel = (a < b) ? -1 : ((a > b) ? 1 : 0);
        k = n;
        if (ee != 0 && x != 0) begin
            p = 7;
            while (!x[p]) p--;
            k = n - p / dg;
        end
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_cmp(input logic [7:0] a, input logic [7:0] b, input logic sm);
        int lat [3];
        int np [3];
        int lt [3];
        int gt [3];
        int eq [3];
        int cy [3];
        int rel;
        int k;
        for (int j = 0; j < 3; j++) begin
            lat[j] = -1; np[j] = 0; lt[j] = -1; gt[j] = -1; eq[j] = -1; cy[j] = -1;
        end
        @(negedge clk);
        t_a = a; t_b = b; t_sm = sm; t_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                if (w_done[j]) begin
                    np[j]++; lat[j] = i;
                    lt[j] = int'(w_lt[j]); gt[j] = int'(w_gt[j]); eq[j] = int'(w_eq[j]);
                    cy[j] = int'(w_cyc[j]);
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            model(a, b, sm, DG[j], EE[j], rel, k);
            chk($sformatf("u%0d a=%h b=%h s=%0d done_pulses", j, a, b, sm), np[j], 1);
            chk($sformatf("u%0d a=%h b=%h s=%0d latency", j, a, b, sm), lat[j], k);
            chk($sformatf("u%0d a=%h b=%h s=%0d cycles", j, a, b, sm), cy[j], k);
            chk($sformatf("u%0d a=%h b=%h s=%0d lesser", j, a, b, sm), lt[j], int'(rel < 0));
            chk($sformatf("u%0d a=%h b=%h s=%0d greater", j, a, b, sm), gt[j], int'(rel > 0));
            chk($sformatf("u%0d a=%h b=%h s=%0d equal", j, a, b, sm), eq[j], int'(rel == 0));
        end
        r0_lt = lt[0]; r0_gt = gt[0]; r0_eq = eq[0]; r0_cyc = cy[0];
    endtask

    vec_t vecs [7];

    initial begin
        int busy_cnt;
        int np;
        int seen;
        int sv_gt;
        int sv_cyc;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{8'd12, 8'd13, 1'b0, 1, 0, 0, 4};
        vecs[1] = '{8'hA5, 8'hA5, 1'b0, 0, 0, 1, 4};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 0, 1, 0, 1};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 1, 0, 0, 1};
        vecs[4] = '{8'hFF, 8'hFE, 1'b1, 0, 1, 0, 4};
        vecs[5] = '{8'hC0, 8'h00, 1'b0, 0, 1, 0, 1};
        vecs[6] = '{8'hF0, 8'h10, 1'b0, 0, 1, 0, 1};

        t_start = 1'b0; t_a = '0; t_b = '0; t_sm = 1'b0;
        rst_n = 1'b0;
        idle(2);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("reset u%0d flags", j),
                int'({w_busy[j], w_done[j], w_lt[j], w_gt[j], w_eq[j]}), 0);
            chk($sformatf("reset u%0d cycles", j), int'(w_cyc[j]), 0);
        end
        rst_n = 1'b1;
        idle(1);

        for (int v = 0; v < 7; v++) begin
            do_cmp(vecs[v].a, vecs[v].b, vecs[v].sm);
            chk($sformatf("vec%0d lesser", v), r0_lt, vecs[v].lt);
            chk($sformatf("vec%0d greater", v), r0_gt, vecs[v].gt);
            chk($sformatf("vec%0d equal", v), r0_eq, vecs[v].eq);
            chk($sformatf("vec%0d cycles", v), r0_cyc, vecs[v].cyc);
        end

        // Back-to-back: restart in the done cycle.
        @(negedge clk);
        t_a = 8'hA5; t_b = 8'hA5; t_sm = 1'b0; t_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_start = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (seen == 0) begin
                @(posedge clk);
                @(negedge clk);
                if (w_done[0]) seen = 1;
            end
        end
        chk("b2b first done seen", seen, 1);
        chk("b2b first equal", int'(w_eq[0]), 1);
        chk("b2b first cycles", int'(w_cyc[0]), 4);
        t_a = 8'hF0; t_b = 8'h10; t_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_start = 1'b0;
        chk("b2b accepted busy", int'(w_busy[0]), 1);
        chk("b2b done cleared", int'(w_done[0]), 0);
        chk("b2b flags held equal", int'(w_eq[0]), 1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b second done", int'(w_done[0]), 1);
        chk("b2b second greater", int'(w_gt[0]), 1);
        chk("b2b second equal", int'(w_eq[0]), 0);
        chk("b2b second cycles", int'(w_cyc[0]), 1);
        idle(8);

        // Start held and operands churning during the scan.
        @(negedge clk);
        t_a = 8'h12; t_b = 8'h13; t_sm = 1'b0; t_start = 1'b1;
        @(posedge clk);
        busy_cnt = 0; np = 0; seen = 0; sv_gt = -1; sv_cyc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (w_busy[0]) busy_cnt++;
            if (w_done[0]) begin
                np++;
                sv_gt = int'(w_gt[0]);
                sv_cyc = int'(w_cyc[0]);
                if (w_lt[0] != 1'b1) sv_gt = -2;
            end
            if (seen == 0 && w_done[0]) begin
                seen = 1;
                t_start = 1'b0;
            end else if (seen == 0) begin
                t_a = 8'($urandom); t_b = 8'($urandom); t_sm = 1'($urandom);
            end
            @(posedge clk);
        end
        t_start = 1'b0;
        chk("hold busy cycles", busy_cnt, 4);
        chk("hold done pulses", np, 1);
        chk("hold lesser result", sv_gt, 0);
        chk("hold cycles", sv_cyc, 4);
        idle(8);

        // Reset mid-scan.
        @(negedge clk);
        t_a = 8'd12; t_b = 8'd13; t_sm = 1'b0; t_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("midreset u%0d flags", j),
                int'({w_busy[j], w_done[j], w_lt[j], w_gt[j], w_eq[j]}), 0);
            chk($sformatf("midreset u%0d cycles", j), int'(w_cyc[j]), 0);
        end
        np = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (w_done != 3'b000) np++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (w_done != 3'b000) np++;
        end
        chk("midreset no done", np, 0);
        do_cmp(8'd3, 8'd3, 1'b0);
        chk("post reset equal", r0_eq, 1);
        chk("post reset cycles", r0_cyc, 4);

        // Randomized compares against the model.
        for (int r = 0; r < 40; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (r % 4 == 0) rb = ra ^ (8'h01 << $urandom_range(0, 7));
            if (r % 9 == 0) rb = ra;
            do_cmp(ra, rb, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator that generalises the 4-bit combinational comparator to WIDTH-bit operands.
- Scans operands MSB-first, DIGIT bits per clock.
- Supports unsigned and two's-complement compare, with optional early exit on the first differing digit.
- Uses a start/busy/done handshake.
- Reports the lesser/greater/equal flags plus the number of scan cycles used.
- Used wherever wide compares must not sit in one combinational path.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2.
- DIGIT, 2, bits compared per clock; WIDTH % DIGIT != 0 is an elaboration error ($error).
- EARLY_EXIT, 1, 1 = finish on first differing digit; 0 = always scan all N = WIDTH/DIGIT digits.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request compare; sampled only when busy = 0.
- a, input, WIDTH, operand A; captured on the start edge.
- b, input, WIDTH, operand B; captured on the start edge.
- signed_mode, input, 1, 1 = two's-complement compare; captured on the start edge.
- busy, output, 1, scan in progress.
- done, output, 1, one-cycle pulse; result valid.
- lesser, output, 1, A < B.
- greater, output, 1, A > B.
- equal, output, 1, A == B.
- cycles, output, $clog2(N+1), scan cycles used by the last compare.

Behaviour:
- Reset (async assert, sync-to-clk deassert is the integrator's job):
  - busy = done = lesser = greater = equal = 0, cycles = 0, state IDLE.
  - Applies immediately, including mid-scan. An aborted scan never produces done.
- States: IDLE and SCAN. All outputs are registered.
- IDLE, start = 1 at an edge:
  - Capture a and b into internal registers.
  - If signed_mode = 1, invert the MSB of both captured copies (offset binary), so the scan is always unsigned.
  - Digit index = N-1, decision = none, count = 0, busy = 1 → SCAN.
- SCAN, each edge:
  - Compare slice [idx*DIGIT +: DIGIT] of A vs B; count++.
  - If decision is none and the slices differ, record lesser/greater.
- SCAN end condition:
  - Leave SCAN on the edge where (EARLY_EXIT = 1 and a decision was just recorded) or idx = 0.
  - On that edge: busy = 0, done = 1, update lesser/greater/equal (equal = no decision) and cycles = count.
  - Otherwise idx-- and stay in SCAN.
- Latency: start edge E0, done high in the cycle after edge E0+k.
  - k = index (1-based, from MSB) of the first differing digit if EARLY_EXIT = 1 and a difference exists.
  - Otherwise k = N.
- done: exactly one cycle. The next edge clears it unless a new result completes.
- Exactly one of lesser/greater/equal is high after the first completed compare. Flags and cycles hold until the next completion; they do not clear on start.
- start while busy = 1 is ignored, with no queueing. a, b and signed_mode changes during SCAN have no effect.
- Back-to-back: start is accepted in the cycle where done = 1 (busy = 0 then), giving zero idle cycles between compares.
- DIGIT = WIDTH: single-cycle compare, cycles = 1.
- EARLY_EXIT = 0: cycles = N always; the decision is frozen at the first difference and later digits are ignored.

Test Plan (WIDTH = 8, DIGIT = 2, EARLY_EXIT = 1 unless stated):
- Unsigned less: a = 8'd12, b = 8'd13, signed_mode = 0 → done after 4 scan cycles, lesser = 1, greater = 0, equal = 0, cycles = 4.
- Equal: a = b = 8'hA5 → equal = 1, cycles = 4. Then, in the done cycle, start again with a = 8'hF0, b = 8'h10 → accepted immediately; greater = 1, cycles = 1.
- Sign mode: a = 8'h80, b = 8'h01. With signed_mode = 0 → greater, cycles = 1. With signed_mode = 1 → lesser (-128 < 1), cycles = 1. Also a = 8'hFF, b = 8'hFE, signed → greater, cycles = 4.
- Handshake: hold start = 1 and change a/b every cycle during SCAN → a single done whose result matches the operands captured at the start edge; busy stays high for exactly k cycles.
- Reset mid-scan: assert rst_n = 0 two cycles after start, between edges → all outputs 0 immediately, no done pulse. After release, a new compare of 8'd3 vs 8'd3 → equal, cycles = 4.
- EARLY_EXIT = 0 instance: a = 8'hC0, b = 8'h00 → greater, cycles = 4, done 4 cycles after start. DIGIT = 8 instance: same operands → cycles = 1.
